// File: rtl/epmp_arb_pkg.sv
// ============================================================================
// Module      : epmp_arb_pkg
// Description : Shared state encoding, owner codes and default timing
//               constants for the EPMP external bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package epmp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_HOST = 2'b10;

  localparam int DEFAULT_WAIT_STATES  = 1;
  localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

`default_nettype wire

// File: rtl/epmp_arb_starve_cnt.sv
// ============================================================================
// Module      : epmp_arb_starve_cnt
// Description : 4-bit saturating counter that tracks how long a host request
//               has been waiting; flags when the limit is reached.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module epmp_arb_starve_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_clr,
  input  logic [3:0] i_limit,
  output logic       o_at_limit
);

  logic [3:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= 4'd0;
    end else if (i_inc && (r_count < i_limit)) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign o_at_limit = (r_count == i_limit);

endmodule

`default_nettype wire

// File: rtl/epmp_bus_arbiter.sv
// ============================================================================
// Module      : epmp_bus_arbiter
// Description : Shares the external memory bus between the EPMP core and the
//               host/debug loader. Optional host bus lock: ARB_HOST_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module epmp_bus_arbiter
  import epmp_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int WAIT_STATES  = DEFAULT_WAIT_STATES,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
`ifdef ARB_HOST_LOCK_EN
  input  logic              host_lock,
`endif
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [1:0]        owner
);

  localparam logic [2:0] c_wait  = 3'(WAIT_STATES);
  localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [2:0]        r_wait;
  logic [1:0]        r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_host_rdata;

  logic w_cpu_req;
  logic w_grant_cpu;
  logic w_grant_host;
  logic w_at_limit;
  logic w_lock_hold;
  logic w_last;

  assign w_cpu_req = cpu_rd | cpu_wr;
  assign w_last    = (r_state == ACCESS) && (r_wait == 3'd0);

`ifdef ARB_HOST_LOCK_EN
  logic r_lock;

  // Lock is armed as a host access enters DONE and consumed by the next IDLE.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_lock <= 1'b0;
    end else if (w_last) begin
      r_lock <= (r_owner == OWN_HOST) && host_lock;
    end else if (r_state == IDLE) begin
      r_lock <= 1'b0;
    end
  end

  assign w_lock_hold = r_lock & host_lock;
`else
  assign w_lock_hold = 1'b0;
`endif

  epmp_arb_starve_cnt u_starve_cnt (
    .clk        (clk),
    .rst        (Reset),
    .i_inc      (host_req & ~w_grant_host),
    .i_clr      (~host_req | w_grant_host),
    .i_limit    (c_limit),
    .o_at_limit (w_at_limit)
  );

  always_comb begin
    w_grant_cpu  = 1'b0;
    w_grant_host = 1'b0;
    if (r_state == IDLE) begin
      if (host_req && (w_at_limit || w_lock_hold)) begin
        w_grant_host = 1'b1;
      end else if (w_cpu_req) begin
        w_grant_cpu = 1'b1;
      end else if (host_req) begin
        w_grant_host = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_grant_cpu || w_grant_host) w_state_nxt = ACCESS;
      ACCESS:  if (r_wait == 3'd0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_owner      <= OWN_NONE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_wait       <= 3'd0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      if (w_grant_cpu) begin
        r_owner <= OWN_CPU;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
        r_we    <= cpu_wr;  // rd and wr together resolve to a write
        r_wait  <= c_wait;
      end else if (w_grant_host) begin
        r_owner <= OWN_HOST;
        r_addr  <= host_addr;
        r_wdata <= host_wdata;
        r_we    <= host_we;
        r_wait  <= c_wait;
      end

      if (r_state == ACCESS) begin
        if (r_wait == 3'd0) begin
          if (!r_we && (r_owner == OWN_CPU))  r_cpu_rdata  <= mem_rdata;
          if (!r_we && (r_owner == OWN_HOST)) r_host_rdata <= mem_rdata;
        end else begin
          r_wait <= r_wait - 3'd1;
        end
      end

      if (r_state == DONE) begin
        r_owner <= OWN_NONE;
      end
    end
  end

  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_rd     = (r_state == ACCESS) && !r_we;
  assign mem_wr     = (r_state == ACCESS) && r_we;
  assign owner      = r_owner;
  assign cpu_rdata  = r_cpu_rdata;
  assign host_rdata = r_host_rdata;
  assign cpu_done   = (r_state == DONE) && (r_owner == OWN_CPU);
  assign host_ack   = (r_state == DONE) && (r_owner == OWN_HOST);
  // Stall is forced low during reset so every output reads 0 there.
  assign cpu_stall  = w_cpu_req & ~cpu_done & ~Reset;

endmodule

`default_nettype wire
